// File: rtl/powerup_scheduler_pkg.sv
// Shared types and constants for the Pong power-up scheduler.
// Used by the interface, the slot timers and the top.
package pong_pp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SPAWN,
    SPAWNED
  } state_t;

  typedef enum logic {
    P1 = 1'b0,
    P2 = 1'b1
  } player_t;

  localparam int MODE_W = 2;
  localparam int NSLOT  = 4;
  localparam int CNT_W  = 4;
  localparam int PRE_W  = 26;

  // x^8+x^6+x^5+x^4+1 on a left-shifting register
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] a,
    input logic [CNT_W-1:0] b
  );
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/powerup_scheduler_if.sv
// Scheduler <-> game-logic bundle: enable/eat requests in,
// token and effect status out.
interface powerup_scheduler_if;

  logic                            enable;
  logic                            eat_p1;
  logic                            eat_p2;
  logic                            spawn;
  logic [pong_pp_pkg::MODE_W-1:0]  spawn_mode;
  logic [pong_pp_pkg::NSLOT-1:0]   pp_status;
  logic [pong_pp_pkg::NSLOT-1:0]   pp_owner;
  logic                            tick;

  modport master (
    output enable, eat_p1, eat_p2,
    input  spawn, spawn_mode,
    input  pp_status, pp_owner, tick
  );

  modport slave (
    input  enable, eat_p1, eat_p2,
    output spawn, spawn_mode,
    output pp_status, pp_owner, tick
  );

endinterface

// File: rtl/powerup_scheduler_pp_slot_timer.sv
// One per-mode effect countdown. PP_STACK_EN makes a reload
// add to the remaining time (saturating) instead of replacing it.
module pp_slot_timer
  import pong_pp_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic [CNT_W-1:0] count,
  output logic             active
);

  assign active = (count != '0);

  // a load in the same cycle as a tick skips the decrement
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
`ifdef PP_STACK_EN
      count <= sat_add(count, load_value);
`else
      count <= load_value;
`endif
    end else if (tick && active) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/powerup_scheduler.sv
// Pong power-up scheduler: 1 Hz prescaler, spawn FSM, LFSR mode pick,
// paddle arbitration and four effect timers (PP_STACK_EN in slot timer).
module powerup_scheduler
  import pong_pp_pkg::*;
#(
  parameter int unsigned PRESCALER   = 64999999,
  parameter int unsigned SPAWN_DELAY = 2,
  parameter int unsigned PP_TIME0    = 3,
  parameter int unsigned PP_TIME1    = 2,
  parameter int unsigned PP_TIME2    = 5,
  parameter int unsigned PP_TIME3    = 4,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input logic               clk,
  input logic               reset,
  powerup_scheduler_if.slave pp
);

  localparam logic [PRE_W-1:0] PRE = PRE_W'(PRESCALER);
  localparam logic [CNT_W-1:0] SD  = CNT_W'(SPAWN_DELAY);
  localparam logic [CNT_W-1:0] PP_T [NSLOT] = '{
    CNT_W'(PP_TIME0), CNT_W'(PP_TIME1),
    CNT_W'(PP_TIME2), CNT_W'(PP_TIME3)
  };

  localparam bit PARAMS_OK =
    (SPAWN_DELAY >= 1) && (SPAWN_DELAY <= 15) &&
    (PP_TIME0 >= 1) && (PP_TIME0 <= 15) &&
    (PP_TIME1 >= 1) && (PP_TIME1 <= 15) &&
    (PP_TIME2 >= 1) && (PP_TIME2 <= 15) &&
    (PP_TIME3 >= 1) && (PP_TIME3 <= 15) &&
    (LFSR_SEED != 8'h00);

  a_params: assert property (@(posedge clk) PARAMS_OK);

  logic [PRE_W-1:0]  presc;
  logic              tick;
  logic [7:0]        lfsr;
  state_t            state, state_n;
  logic [CNT_W-1:0]  delay, delay_n;
  logic [MODE_W-1:0] mode_q, mode_n;
  player_t           last_grant, grant_n;
  logic [NSLOT-1:0]  owner_q, owner_n;
  logic [NSLOT-1:0]  load;
  logic [NSLOT-1:0]  active;
  logic [CNT_W-1:0]  count [NSLOT];

  assign tick = pp.enable && (presc == PRE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (pp.enable) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  // free-running so the mode pick depends on wall-clock timing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      delay      <= '0;
      mode_q     <= '0;
      last_grant <= P2;
      owner_q    <= '0;
    end else begin
      state      <= state_n;
      delay      <= delay_n;
      mode_q     <= mode_n;
      last_grant <= grant_n;
      owner_q    <= owner_n;
    end
  end

  always_comb begin
    state_n = state;
    delay_n = delay;
    mode_n  = mode_q;
    grant_n = last_grant;
    owner_n = owner_q;
    load    = '0;
    if (!pp.enable) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          delay_n = SD;
          state_n = WAIT_SPAWN;
        end
        WAIT_SPAWN: begin
          if (tick) begin
            if (delay == CNT_W'(1)) begin
              state_n = SPAWNED;
              mode_n  = lfsr[MODE_W-1:0];
            end else begin
              delay_n = delay - 1'b1;
            end
          end
        end
        SPAWNED: begin
          if (pp.eat_p1 || pp.eat_p2) begin
            unique case (1'b1)
              pp.eat_p1 && pp.eat_p2:
                grant_n = player_t'(~last_grant);
              pp.eat_p2 && !pp.eat_p1:
                grant_n = P2;
              default:
                grant_n = P1;
            endcase
            load[mode_q]    = 1'b1;
            owner_n[mode_q] = grant_n;
            delay_n         = SD;
            state_n         = WAIT_SPAWN;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    pp.spawn      = (state == SPAWNED);
    pp.spawn_mode = mode_q;
    pp.pp_status  = active;
    pp.pp_owner   = owner_q;
    pp.tick       = tick;
  end

  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    pp_slot_timer u_timer (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .load       (load[i]),
      .load_value (PP_T[i]),
      .count      (count[i]),
      .active     (active[i])
    );

    a_active: assert property (@(posedge clk) disable iff (reset)
      active[i] == (count[i] != '0));
  end

endmodule
